// File: rtl/uvmt_cv32e40s_sl_obi_responder.sv
// OBI memory-side responder: grants requests, queues up to DEPTH transactions and answers in order
// after LATENCY head cycles, echoing each request's attribute and flagging unstable initiator requests.
module uvmt_cv32e40s_sl_obi_responder #(
    parameter int ATTR_W  = 1,
    parameter int DEPTH   = 2,
    parameter int LATENCY = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [ATTR_W-1:0] attr_i,
    input  logic              gnt_stall_i,
    input  logic              rvalid_stall_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic [ATTR_W-1:0] rattr_o,
    output logic [3:0]        outstanding_o,
    output logic              protocol_err_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
    localparam logic [3:0]       LAT_C    = 4'(LATENCY);

    logic [31:0]       addr_mem [DEPTH];
    logic              we_mem   [DEPTH];
    logic [ATTR_W-1:0] attr_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        count_q, count_d;
    logic [3:0]        head_wait_q, head_wait_d;
    logic              lat_ok;
    logic              push;
    logic              pop;

    logic              pend_q;
    logic [31:0]       pend_addr_q;
    logic              pend_we_q;
    logic [ATTR_W-1:0] pend_attr_q;
    logic              perr_q, perr_d;

    // Slot availability uses the registered count only, so a same-cycle pop never frees a grant.
    assign gnt_o    = req_i && !gnt_stall_i && (count_q < DEPTH_C) && !rst_i;
    assign rvalid_o = (count_q != 4'd0) && lat_ok && !rvalid_stall_i && !rst_i;
    assign push     = gnt_o;
    assign pop      = rvalid_o;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign lat_ok = 1'b1;
        end else begin : g_latn
            assign lat_ok = (head_wait_q >= LAT_C);
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        head_wait_d = head_wait_q;
        count_d     = count_q + {3'b000, push} - {3'b000, pop};
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        // A fresh head (into an empty queue, or behind a popped one) restarts its wait.
        if ((push && (count_q == 4'd0)) || (pop && ((count_q > 4'd1) || push))) begin
            head_wait_d = '0;
        end else if ((count_q != 4'd0) && !lat_ok) begin
            head_wait_d = head_wait_q + 4'd1;
        end
    end

    assign perr_d = perr_q || (pend_q && (!req_i || (addr_i != pend_addr_q) ||
                                          (we_i != pend_we_q) || (attr_i != pend_attr_q)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_wait_q <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_we_q   <= 1'b0;
            pend_attr_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_wait_q <= head_wait_d;
            pend_q      <= req_i && !gnt_o;
            pend_addr_q <= addr_i;
            pend_we_q   <= we_i;
            pend_attr_q <= attr_i;
            perr_q      <= perr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= addr_i;
            we_mem[wr_ptr_q]   <= we_i;
            attr_mem[wr_ptr_q] <= attr_i;
        end
    end

    assign outstanding_o  = count_q;
    assign rdata_o        = (rvalid_o && !we_mem[rd_ptr_q]) ? addr_mem[rd_ptr_q] : 32'h0;
    assign rattr_o        = rvalid_o ? attr_mem[rd_ptr_q] : '0;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_obi_responder.sv
// Directed bench: three responder instances (L0/D2, L3/D2, L0/D3) share one stimulus stream;
// each phase checks only the instance it targets.
module tb_uvmt_cv32e40s_sl_obi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [0:0]  attr;
    logic        gs;
    logic        rs;

    logic        gnt_a, rv_a, ra_a, pe_a;
    logic        gnt_b, rv_b, ra_b, pe_b;
    logic        gnt_c, rv_c, ra_c, pe_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic [3:0]  out_a, out_b, out_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uvmt_cv32e40s_sl_obi_responder #(.ATTR_W(1), .DEPTH(2), .LATENCY(0)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .attr_i(attr),
        .gnt_stall_i(gs), .rvalid_stall_i(rs), .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rd_a),
        .rattr_o(ra_a), .outstanding_o(out_a), .protocol_err_o(pe_a));

    uvmt_cv32e40s_sl_obi_responder #(.ATTR_W(1), .DEPTH(2), .LATENCY(3)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .attr_i(attr),
        .gnt_stall_i(gs), .rvalid_stall_i(rs), .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rd_b),
        .rattr_o(ra_b), .outstanding_o(out_b), .protocol_err_o(pe_b));

    uvmt_cv32e40s_sl_obi_responder #(.ATTR_W(1), .DEPTH(3), .LATENCY(0)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .attr_i(attr),
        .gnt_stall_i(gs), .rvalid_stall_i(rs), .gnt_o(gnt_c), .rvalid_o(rv_c), .rdata_o(rd_c),
        .rattr_o(ra_c), .outstanding_o(out_c), .protocol_err_o(pe_c));

    typedef struct {
        logic        dut;   // 0: instance A, 1: instance B
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic        attr;
        logic        gs;
        logic        rs;
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_rattr;
        logic [3:0]  e_out;
        logic        e_perr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rattr;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    function automatic vec_t V(input logic d, input logic r, input logic q, input logic [31:0] a,
                               input logic w, input logic at, input logic s_g, input logic s_r,
                               input logic eg, input logic ev, input logic [31:0] ed,
                               input logic era, input logic [3:0] eo, input logic ep);
        vec_t v;
        v = '{dut: d, rst: r, req: q, addr: a, we: w, attr: at, gs: s_g, rs: s_r,
              e_gnt: eg, e_rv: ev, e_rdata: ed, e_rattr: era, e_out: eo, e_perr: ep};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic [31:0] a, input logic w,
                         input logic at, input logic s_g, input logic s_r);
        rst  = r;
        req  = q;
        addr = a;
        we   = w;
        attr = at;
        gs   = s_g;
        rs   = s_r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        g, v, ra, pe;
        logic [31:0] rd;
        logic [3:0]  o;
        int          idx, resp, cnt, cyc;
        exp_t        e;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- instance A (LATENCY=0, DEPTH=2) ----------------
        //             d  r  q  addr     w  at gs rs | gnt rv rdata   ra out pe
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h100, 0, 1, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h100, 1, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        // fill under rvalid stall, third request waits for a slot
        vq.push_back(V(0, 0, 1, 32'h200, 0, 1, 0, 1,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h204, 1, 0, 0, 1,   1,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(0, 0, 1, 32'h208, 0, 1, 0, 1,   0,  0, 32'h000, 0, 2, 0));
        vq.push_back(V(0, 0, 1, 32'h208, 0, 1, 0, 1,   0,  0, 32'h000, 0, 2, 0));
        vq.push_back(V(0, 0, 1, 32'h208, 0, 1, 0, 0,   0,  1, 32'h200, 1, 2, 0));
        vq.push_back(V(0, 0, 1, 32'h208, 0, 1, 0, 0,   1,  1, 32'h000, 0, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h208, 1, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        // push and pop at the same edge with one entry queued
        vq.push_back(V(0, 0, 1, 32'h300, 0, 0, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h304, 0, 1, 0, 0,   1,  1, 32'h300, 0, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h304, 1, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        // address changes while stalled
        vq.push_back(V(0, 0, 1, 32'h010, 0, 0, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h010, 0, 0, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h014, 0, 0, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 1));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 1));
        // attribute change while stalled
        vq.push_back(V(0, 1, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h020, 0, 0, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h020, 0, 1, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 1));
        // request dropped while stalled
        vq.push_back(V(0, 1, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h030, 0, 0, 1, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 1));
        // no grant while in reset, normal service afterwards
        vq.push_back(V(0, 1, 1, 32'h030, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 32'h030, 0, 0, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h030, 0, 1, 0));
        vq.push_back(V(0, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));

        // ---------------- instance B (LATENCY=3, DEPTH=2) ----------------
        vq.push_back(V(1, 1, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(1, 0, 1, 32'h040, 0, 1, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h040, 1, 1, 0));
        vq.push_back(V(1, 0, 1, 32'h044, 1, 0, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h000, 0, 1, 0));
        // second entry restarts its wait once it becomes head
        vq.push_back(V(1, 0, 1, 32'h050, 0, 1, 0, 0,   1,  0, 32'h000, 0, 0, 0));
        vq.push_back(V(1, 0, 1, 32'h054, 0, 0, 0, 0,   1,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 2, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 2, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h050, 1, 2, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  1, 32'h054, 0, 1, 0));
        vq.push_back(V(1, 0, 0, 32'h000, 0, 0, 0, 0,   0,  0, 32'h000, 0, 0, 0));

        // reset state, with a request pending that must not be granted
        next_cycle();
        drive(1'b1, 1'b1, 32'h0bad, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst gnt_a", 32'(gnt_a), 32'h0);
        chk("rst rvalid_a", 32'(rv_a), 32'h0);
        chk("rst out_a", 32'(out_a), 32'h0);
        chk("rst perr_a", 32'(pe_a), 32'h0);
        chk("rst out_c", 32'(out_c), 32'h0);

        foreach (vq[i]) begin
            next_cycle();
            drive(vq[i].rst, vq[i].req, vq[i].addr, vq[i].we, vq[i].attr, vq[i].gs, vq[i].rs);
            #2;
            g  = vq[i].dut ? gnt_b : gnt_a;
            v  = vq[i].dut ? rv_b  : rv_a;
            rd = vq[i].dut ? rd_b  : rd_a;
            ra = vq[i].dut ? ra_b  : ra_a;
            o  = vq[i].dut ? out_b : out_a;
            pe = vq[i].dut ? pe_b  : pe_a;
            chk($sformatf("vec%0d gnt", i), 32'(g), 32'(vq[i].e_gnt));
            chk($sformatf("vec%0d rvalid", i), 32'(v), 32'(vq[i].e_rv));
            chk($sformatf("vec%0d rdata", i), rd, vq[i].e_rdata);
            chk($sformatf("vec%0d rattr", i), 32'(ra), 32'(vq[i].e_rattr));
            chk($sformatf("vec%0d outstanding", i), 32'(o), 32'(vq[i].e_out));
            chk($sformatf("vec%0d perr", i), 32'(pe), 32'(vq[i].e_perr));
        end

        // asynchronous reset in mid-cycle with two transactions outstanding on A
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("arst pre out_a", 32'(out_a), 32'h2);
        #2;
        rst = 1'b1;
        rs  = 1'b0;
        #1;
        chk("arst rvalid_a", 32'(rv_a), 32'h0);
        chk("arst out_a", 32'(out_a), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("post-arst%0d rvalid_a", k), 32'(rv_a), 32'h0);
            chk($sformatf("post-arst%0d out_a", k), 32'(out_a), 32'h0);
            next_cycle();
        end

        // 20 transactions through instance C (DEPTH=3) to wrap the pointers
        idx  = 0;
        resp = 0;
        cnt  = 0;
        cyc  = 0;
        while (resp < 20 && cyc < 300) begin
            drive(1'b0, idx < 20, 32'h1000 + 32'(idx) * 4, (idx % 3) == 2,
                  1'((idx ^ (idx >> 2)) & 1), (cyc % 5) == 3, (cyc % 3) == 1);
            #2;
            g = req && !gs && (cnt < 3);
            v = (cnt != 0) && !rs;
            chk($sformatf("wrap c%0d out_c", cyc), 32'(out_c), 32'(cnt));
            chk($sformatf("wrap c%0d gnt_c", cyc), 32'(gnt_c), 32'(g));
            chk($sformatf("wrap c%0d rvalid_c", cyc), 32'(rv_c), 32'(v));
            if (v) begin
                e = sb.pop_front();
                chk($sformatf("wrap r%0d rdata", resp), rd_c, e.rdata);
                chk($sformatf("wrap r%0d rattr", resp), 32'(ra_c), 32'(e.rattr));
                resp++;
                cnt--;
            end
            if (g) begin
                e.rdata = we ? 32'h0 : addr;
                e.rattr = attr[0];
                sb.push_back(e);
                idx++;
                cnt++;
            end
            cyc++;
            next_cycle();
        end
        checks++;
        if (resp != 20) begin
            errors++;
            $display("FAIL wrap timeout: got %0d responses expected 20", resp);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("wrap final out_c", 32'(out_c), 32'h0);
        chk("wrap final perr_c", 32'(pe_c), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
